// File: rtl/einstein_kbd_matrix.sv
// einstein_kbd_matrix
// Turns MiSTer ps2_key events into the Tatung Einstein 8x8 keyboard matrix
// and the separate modifier lines. It also drives the keypress line that the
// system core uses for its keyboard interrupt.
//
// Ports
//   clk_sys   in   system clock
//   reset     in   asynchronous, active-high
//   ps2_key   in   [10] toggle strobe, [9] pressed, [8] E0-extended, [7:0] set-2 code
//   kb_row    in   row select, active-low (several rows may be low at once)
//   kb_col    out  column sense, active-low, registered
//   kb_shift  out  active-low, low while either shift key is held
//   kb_ctrl   out  active-low
//   kb_graph  out  active-low
//   kb_down   out  high while a matrix key is held, with a short low gap on each new press
//   dbg_state out  current kb_down FSM state
//
// Event semantics: ps2_key has no valid/ready handshake. Each change of
// ps2_key[10] carries exactly one event. The block never stalls, so it
// accepts one event per clk_sys cycle.
module einstein_kbd_matrix #(
  parameter int NEWKEY_GAP = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  kb_row,
  output logic [7:0]  kb_col,
  output logic        kb_shift,
  output logic        kb_ctrl,
  output logic        kb_graph,
  output logic        kb_down,
  output logic [1:0]  dbg_state
);

  localparam int CW = (NEWKEY_GAP < 2) ? 1 : $clog2(NEWKEY_GAP + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DOWN = 2'd1, GAP = 2'd2} state_t;

  // Key map: {valid, row[2:0], col[2:0]}, keyed on {ext, code}.
  function automatic logic [6:0] keymap(input logic [8:0] k);
    logic [6:0] m;
    m = 7'd0;
    case (k)
      9'h029: m = {1'b1, 6'o00};  9'h066: m = {1'b1, 6'o05};
      9'h076: m = {1'b1, 6'o06};  9'h05A: m = {1'b1, 6'o07};
      9'h01C: m = {1'b1, 6'o10};  9'h032: m = {1'b1, 6'o11};
      9'h021: m = {1'b1, 6'o12};  9'h023: m = {1'b1, 6'o13};
      9'h024: m = {1'b1, 6'o14};  9'h02B: m = {1'b1, 6'o15};
      9'h034: m = {1'b1, 6'o16};  9'h033: m = {1'b1, 6'o17};
      9'h043: m = {1'b1, 6'o20};  9'h03B: m = {1'b1, 6'o21};
      9'h042: m = {1'b1, 6'o22};  9'h04B: m = {1'b1, 6'o23};
      9'h03A: m = {1'b1, 6'o24};  9'h031: m = {1'b1, 6'o25};
      9'h044: m = {1'b1, 6'o26};  9'h04D: m = {1'b1, 6'o27};
      9'h015: m = {1'b1, 6'o30};  9'h02D: m = {1'b1, 6'o31};
      9'h01B: m = {1'b1, 6'o32};  9'h02C: m = {1'b1, 6'o33};
      9'h03C: m = {1'b1, 6'o34};  9'h02A: m = {1'b1, 6'o35};
      9'h01D: m = {1'b1, 6'o36};  9'h022: m = {1'b1, 6'o37};
      9'h035: m = {1'b1, 6'o40};  9'h01A: m = {1'b1, 6'o41};
      9'h016: m = {1'b1, 6'o42};  9'h01E: m = {1'b1, 6'o43};
      9'h026: m = {1'b1, 6'o44};  9'h025: m = {1'b1, 6'o45};
      9'h02E: m = {1'b1, 6'o46};  9'h036: m = {1'b1, 6'o47};
      9'h03D: m = {1'b1, 6'o50};  9'h03E: m = {1'b1, 6'o51};
      9'h046: m = {1'b1, 6'o52};  9'h045: m = {1'b1, 6'o53};
      9'h04E: m = {1'b1, 6'o54};  9'h055: m = {1'b1, 6'o55};
      9'h041: m = {1'b1, 6'o56};  9'h049: m = {1'b1, 6'o57};
      9'h04A: m = {1'b1, 6'o60};  9'h04C: m = {1'b1, 6'o61};
      9'h052: m = {1'b1, 6'o62};  9'h054: m = {1'b1, 6'o63};
      9'h05B: m = {1'b1, 6'o64};  9'h05D: m = {1'b1, 6'o65};
      9'h00E: m = {1'b1, 6'o66};  9'h00D: m = {1'b1, 6'o67};
      9'h16B: m = {1'b1, 6'o70};  9'h174: m = {1'b1, 6'o71};
      9'h172: m = {1'b1, 6'o72};  9'h175: m = {1'b1, 6'o73};
      9'h005: m = {1'b1, 6'o74};  9'h006: m = {1'b1, 6'o75};
      9'h004: m = {1'b1, 6'o76};  9'h00C: m = {1'b1, 6'o77};
      default: m = 7'd0;
    endcase
    return m;
  endfunction

  // Stage 0: register the raw key. The first cycle after reset only primes
  // the previous-toggle register, so whatever ps2_key[10] holds then is not an event.
  logic [10:0] key_q;
  logic        tog_q, armed_q, ev0;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      key_q   <= '0;
      tog_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      key_q   <= ps2_key;
      armed_q <= 1'b1;
      tog_q   <= armed_q ? key_q[10] : ps2_key[10];
    end
  end

  assign ev0 = armed_q & (key_q[10] ^ tog_q);

  // Stage 1: key map lookup and modifier decode.
  logic [6:0] lk;
  logic [3:0] mod0;  // {graph, ctrl, rshift, lshift}
  logic       s1_valid, s1_pressed, s1_mapped;
  logic [5:0] s1_rc;
  logic [3:0] s1_mod;

  assign lk      = keymap(key_q[8:0]);
  assign mod0[0] = (key_q[7:0] == 8'h12) & ~key_q[8];
  assign mod0[1] = (key_q[7:0] == 8'h59) & ~key_q[8];
  assign mod0[2] = (key_q[7:0] == 8'h14);
  assign mod0[3] = (key_q[7:0] == 8'h11);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_pressed <= 1'b0;
      s1_mapped  <= 1'b0;
      s1_rc      <= '0;
      s1_mod     <= '0;
    end else begin
      s1_valid   <= ev0;
      s1_pressed <= key_q[9];
      s1_mapped  <= lk[6];
      s1_rc      <= lk[5:0];
      s1_mod     <= mod0;
    end
  end

  // Stage 2: matrix and modifier state. A new press is a 0->1 matrix
  // transition while some other key is already down. Typematic repeats of a
  // held key do not count as new presses.
  logic [63:0] mat;
  logic        lshift, rshift, ctrl, graph, np_q, any_key, new_press;

  assign any_key   = |mat;
  assign new_press = s1_valid & s1_mapped & s1_pressed & ~mat[s1_rc] & any_key;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mat    <= '0;
      lshift <= 1'b0;
      rshift <= 1'b0;
      ctrl   <= 1'b0;
      graph  <= 1'b0;
      np_q   <= 1'b0;
    end else begin
      np_q <= new_press;
      if (s1_valid) begin
        if (s1_mod[0]) lshift <= s1_pressed;
        if (s1_mod[1]) rshift <= s1_pressed;
        if (s1_mod[2]) ctrl   <= s1_pressed;
        if (s1_mod[3]) graph  <= s1_pressed;
        if (s1_mapped) mat[s1_rc] <= s1_pressed;
      end
    end
  end

  assign kb_shift = ~(lshift | rshift);
  assign kb_ctrl  = ~ctrl;
  assign kb_graph = ~graph;

  // Column sense: OR every selected row of the matrix, then register the result.
  logic [7:0] col_n;

  always_comb begin
    col_n = 8'hFF;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (!kb_row[r] && mat[r*8+c]) col_n[c] = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) kb_col <= 8'hFF;
    else       kb_col <= col_n;
  end

  // kb_down FSM. In GAP, the state lasts NEWKEY_GAP cycles after the last new press.
  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: if (any_key) state_n = DOWN;
      DOWN: begin
        if (!any_key) state_n = IDLE;
        else if (np_q) begin
          state_n = GAP;
          cnt_n   = CW'(NEWKEY_GAP);
        end
      end
      GAP: begin
        if (np_q) cnt_n = CW'(NEWKEY_GAP);
        else if (cnt_q <= CW'(1)) begin
          state_n = any_key ? DOWN : IDLE;
          cnt_n   = '0;
        end else cnt_n = cnt_q - CW'(1);
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign kb_down   = (state_q == DOWN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// Bench for einstein_kbd_matrix: a table of single events with expected
// outputs, plus hand-written sequences for the gap pulse, typematic repeats,
// back-to-back events and asynchronous reset.
module tb_einstein_kbd_matrix;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  kb_row;
  logic [7:0]  kb_col;
  logic        kb_shift, kb_ctrl, kb_graph, kb_down;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Expected output records {kb_col, kb_shift, kb_ctrl, kb_graph, kb_down}.
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0]  row;
    logic        ext;
    logic [7:0]  code;
    logic        pr;
    logic [11:0] exp;
  } vec_t;

  vec_t vec[27];

  einstein_kbd_matrix #(.NEWKEY_GAP(2)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .kb_row   (kb_row),
    .kb_col   (kb_col),
    .kb_shift (kb_shift),
    .kb_ctrl  (kb_ctrl),
    .kb_graph (kb_graph),
    .kb_down  (kb_down),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk_sys = ~clk_sys;

  // Driver tasks. Inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic ext, input logic [7:0] code, input logic pr);
    ps2_key = {~ps2_key[10], pr, ext, code};
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {kb_col, kb_shift, kb_ctrl, kb_graph, kb_down};
  endfunction

  initial begin
    // Table: row select, event, and expected outputs 4 cycles after the toggle.
    vec[0]  = '{8'hFD, 1'b0, 8'h1C, 1'b1, {8'hFE, 4'b1111}};
    vec[1]  = '{8'hFD, 1'b0, 8'h1C, 1'b0, {8'hFF, 4'b1110}};
    vec[2]  = '{8'hFE, 1'b0, 8'h29, 1'b1, {8'hFE, 4'b1111}};
    vec[3]  = '{8'hFE, 1'b0, 8'h5A, 1'b1, {8'h7E, 4'b1110}};
    vec[4]  = '{8'hFE, 1'b0, 8'h76, 1'b1, {8'h3E, 4'b1110}};
    vec[5]  = '{8'hFE, 1'b0, 8'h29, 1'b0, {8'h3F, 4'b1111}};
    vec[6]  = '{8'hFE, 1'b0, 8'h5A, 1'b0, {8'hBF, 4'b1111}};
    vec[7]  = '{8'hFE, 1'b0, 8'h76, 1'b0, {8'hFF, 4'b1110}};
    vec[8]  = '{8'hFF, 1'b0, 8'h12, 1'b1, {8'hFF, 4'b0110}};
    vec[9]  = '{8'hFF, 1'b0, 8'h59, 1'b1, {8'hFF, 4'b0110}};
    vec[10] = '{8'hFF, 1'b0, 8'h12, 1'b0, {8'hFF, 4'b0110}};
    vec[11] = '{8'hFF, 1'b0, 8'h59, 1'b0, {8'hFF, 4'b1110}};
    vec[12] = '{8'hFF, 1'b0, 8'h14, 1'b1, {8'hFF, 4'b1010}};
    vec[13] = '{8'hFF, 1'b1, 8'h14, 1'b0, {8'hFF, 4'b1110}};
    vec[14] = '{8'hFF, 1'b1, 8'h11, 1'b1, {8'hFF, 4'b1100}};
    vec[15] = '{8'hFF, 1'b0, 8'h11, 1'b0, {8'hFF, 4'b1110}};
    vec[16] = '{8'h7F, 1'b1, 8'h75, 1'b1, {8'hF7, 4'b1111}};
    vec[17] = '{8'h7F, 1'b1, 8'h75, 1'b1, {8'hF7, 4'b1111}};
    vec[18] = '{8'h7F, 1'b0, 8'h07, 1'b1, {8'hF7, 4'b1111}};
    vec[19] = '{8'h7F, 1'b1, 8'h12, 1'b1, {8'hF7, 4'b1111}};
    vec[20] = '{8'h7F, 1'b1, 8'h59, 1'b1, {8'hF7, 4'b1111}};
    vec[21] = '{8'hFF, 1'b1, 8'h75, 1'b1, {8'hFF, 4'b1111}};
    vec[22] = '{8'h7F, 1'b1, 8'h75, 1'b0, {8'hFF, 4'b1110}};
    vec[23] = '{8'hFC, 1'b0, 8'h1C, 1'b1, {8'hFE, 4'b1111}};
    vec[24] = '{8'hFC, 1'b0, 8'h5A, 1'b1, {8'h7E, 4'b1110}};
    vec[25] = '{8'hFD, 1'b0, 8'h5A, 1'b0, {8'hFE, 4'b1111}};
    vec[26] = '{8'hFD, 1'b0, 8'h1C, 1'b0, {8'hFF, 4'b1110}};

    // Reset block.
    reset   = 1'b1;
    ps2_key = 11'h000;
    kb_row  = 8'hFF;
    #1;
    check("reset_outputs", outs(), {8'hFF, 4'b1110});
    tick(3);
    reset = 1'b0;
    tick(4);
    check("idle_after_reset", outs(), {8'hFF, 4'b1110});

    // Table-driven single events through the scoreboard.
    foreach (vec[i]) begin
      kb_row = vec[i].row;
      send(vec[i].ext, vec[i].code, vec[i].pr);
      exp_q.push_back(vec[i].exp);
      tick(4);
      check($sformatf("vec%0d", i), outs(), exp_q.pop_front());
    end
    tick(6);

    // kb_down low for exactly NEWKEY_GAP cycles on a second press.
    kb_row = 8'hFE;
    send(1'b0, 8'h29, 1'b1);
    tick(8);
    send(1'b0, 8'h5A, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("gap_cycle%0d", k), {11'd0, kb_down}, (k == 4 || k == 5) ? 12'd0 : 12'd1);
    end
    check("gap_col", {4'd0, kb_col}, 12'h07E);
    send(1'b0, 8'h29, 1'b0);
    tick(1);
    send(1'b0, 8'h5A, 1'b0);
    tick(6);
    check("gap_release", outs(), {8'hFF, 4'b1110});

    // Typematic repeats of a held key: no gap pulse.
    kb_row = 8'h7F;
    send(1'b1, 8'h75, 1'b1);
    tick(8);
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 8'h75, 1'b1);
      tick(1);
      check($sformatf("typematic%0d", k), {11'd0, kb_down}, 12'd1);
    end
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check($sformatf("typematic_tail%0d", k), {11'd0, kb_down}, 12'd1);
    end
    check("typematic_col", {4'd0, kb_col}, 12'h0F7);
    send(1'b1, 8'h75, 1'b0);
    tick(6);
    check("typematic_release", outs(), {8'hFF, 4'b1110});

    // Back-to-back events on consecutive cycles.
    kb_row = 8'hFC;
    send(1'b0, 8'h32, 1'b1);
    tick(1);
    send(1'b0, 8'h32, 1'b0);
    tick(1);
    send(1'b0, 8'h29, 1'b1);
    tick(8);
    check("b2b_state", outs(), {8'hFE, 4'b1111});
    send(1'b0, 8'h29, 1'b0);
    tick(6);
    check("b2b_release", outs(), {8'hFF, 4'b1110});

    // Asynchronous reset while 3 keys and shift are held.
    kb_row = 8'h00;
    send(1'b0, 8'h29, 1'b1);
    tick(8);
    send(1'b0, 8'h1C, 1'b1);
    tick(8);
    send(1'b1, 8'h75, 1'b1);
    tick(8);
    send(1'b0, 8'h12, 1'b1);
    tick(6);
    check("held3", outs(), {8'hF6, 4'b0111});
    @(posedge clk_sys);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", outs(), {8'hFF, 4'b1110});
    send(1'b0, 8'h1C, 1'b1);
    tick(2);
    reset = 1'b0;
    tick(6);
    check("no_spurious_event", outs(), {8'hFF, 4'b1110});
    send(1'b0, 8'h1C, 1'b1);
    tick(4);
    check("press_after_reset", outs(), {8'hFE, 4'b1111});

    // Final report.
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/einstein_kbd_matrix.md
# einstein_kbd_matrix

Converts MiSTer `ps2_key` events into the Tatung Einstein keyboard matrix and modifier lines. It sits directly upstream of the Einstein system core, which consumes `kb_col`, `kb_shift`, `kb_ctrl`, `kb_graph` and `kb_down`. It tracks an 8×8 key-state matrix, left and right shift independently, and a keypress event line that drives the core's keyboard interrupt.

## Interface
- `NEWKEY_GAP`, default 2: number of clk_sys cycles `kb_down` is held low to mark a new press while other keys are already down.
- `clk_sys`  in  1  system clock (32 MHz).
- `reset`  in  1  asynchronous, active-high.
- `ps2_key`  in  11  bit10 = toggle strobe, bit9 = pressed, bit8 = E0-extended, bits7:0 = set-2 scancode.
- `kb_row`  in  8  row select from the PSG port A; active-low, several rows may be low at once.
- `kb_col`  out  8  column sense to the PSG port B; active-low.
- `kb_shift`, `kb_ctrl`, `kb_graph`  out  1 each  modifiers; active-low (1 = released).
- `kb_down`  out  1  high while at least one matrix key is held.

## Operation
- Stage 0: register `ps2_key`. A change of bit10 relative to its previous value is one event. Identical toggle values produce no event.
- Stage 1: look up the row, column and valid flag from {ext, code} in the block's key map. The map includes these entries:
  - 0x29 (space) → r0 c0
  - 0x1C (A) → r1 c0
  - 0x5A (Enter) → r0 c7
  - E0 0x75 (cursor up) → r7 c3
  - 0x76 (Esc) → r0 c6
- Modifiers are handled outside the matrix:
  - 0x12 sets or clears `lshift`; 0x59 sets or clears `rshift`.
  - 0x14 (plain or E0) sets or clears `ctrl`.
  - 0x11 (plain or E0) sets or clears `graph`.
  - `kb_shift = ~(lshift|rshift)`, `kb_ctrl = ~ctrl`, `kb_graph = ~graph`.
- Stage 2: update the matrix.
  - A press sets `mat[r][c]`; a release clears it.
  - Unmapped codes and E0 12 / E0 59 (fake shifts) are ignored.
  - A repeated press of a key already set (typematic) makes no change and produces no new-press event.
- `kb_col[c]` is 0 if any row r with `kb_row[r]==0` has `mat[r][c]==1`; otherwise 1. If `kb_row` is 0xFF, `kb_col` is 0xFF.
- `kb_down` FSM, where `any = |mat`:
  - IDLE (kb_down=0): go to DOWN when `any` is 1.
  - DOWN (kb_down=1):
    - `any` is 0 → IDLE.
    - A new press occurs (a bit goes 0→1 while `any` was already 1) → GAP, with the counter loaded with NEWKEY_GAP.
  - GAP (kb_down=0): decrement the counter each cycle. At 0, go to DOWN if `any` is 1, otherwise IDLE.
  - A new press during GAP reloads the counter.
  - A release-to-empty during GAP leaves the state in GAP until the counter expires, then goes to IDLE.
  - Modifiers never affect `kb_down`.

## Timing
- Reset values:
  - `mat` = 0, all modifier flags = 0, previous toggle = `ps2_key[10]` sampled after reset.
  - FSM = IDLE.
  - Outputs: `kb_col`=0xFF, `kb_shift`=`kb_ctrl`=`kb_graph`=1, `kb_down`=0.
- Reset mid-sequence drops all held keys immediately. No release events are needed afterwards.
- Latency from a `ps2_key` toggle change to the matrix or modifier update is 3 clk_sys cycles.
- `kb_col` is registered: it reflects `kb_row` and `mat` from the previous cycle. Total latency from toggle to `kb_col` is 4 cycles.
- `kb_down` is registered off `mat`: it rises 1 cycle after the first matrix bit is set.
- Events arriving on consecutive cycles are all processed; the pipeline accepts one event per cycle.
- A press and a release of the same key in adjacent events leaves the key cleared.

## Test plan
- Reset, then press 0x1C with `kb_row`=0xFD → `kb_col`=0xFE 4 cycles after the toggle, and `kb_down` rises; release 0x1C → `kb_col`=0xFF and `kb_down`=0.
- Hold 0x29, press 0x5A with `kb_row`=0xFE → `kb_col`=0x7E, and `kb_down` goes low for exactly 2 cycles then high again.
- Press 0x12 then 0x59, release 0x12 → `kb_shift` stays 0; release 0x59 → `kb_shift`=1; `kb_down` stays 0 throughout.
- Press E0 0x75, then send the same press event 5 times (typematic) → `mat[7][3]`=1, and no GAP pulse occurs on `kb_down`.
- Press unmapped code 0x07 and fake shift E0 0x12 → no change on any output.
- Hold 3 keys, assert `reset` asynchronously → `kb_col`=0xFF and `kb_down`=0 immediately, and there is no spurious event when `reset` is released.
